jtag_shift_serdes: RTL
======================

# jtag_shift_serdes

Byte-to-bit bridge between the host-side stream FIFOs and the TAP controller's shift port. Serializes upstream bytes LSB-first onto `shift_in` and drives `shift_ready` so the TAP FSM enters PAUSE_xR when data runs dry. In the same cycle it packs the returned `shift_out` bits into bytes for the downstream readback FIFO. One TDI bit is consumed and one TDO bit is produced for every clock that `tap_shift` is high.

## Interface
- `RX_DEPTH`, 4: readback FIFO entries, power of two ≥ 2.
- `clk` in 1: TCK-domain clock, the same clock the TAP FSM runs on.
- `rst_n` in 1: synchronous, active-low reset.
- `tx_data` in 8: next TDI byte, bit 0 shifted first.
- `tx_nbits` in 4: valid bits in `tx_data`, 1..8. Sampled only with `tx_last`; otherwise 8 is implied.
- `tx_last` in 1: this byte ends the current transfer.
- `tx_valid` in 1 / `tx_ready` out 1: upstream handshake. A byte is accepted when both are high at a posedge.
- `shift_in` out 1: current TDI bit to the TAP FSM.
- `shift_ready` out 1: low means the current bit is the last buffered bit and no transfer end is pending.
- `tap_shift` in 1: TAP FSM is in SHIFT_DR/SHIFT_IR.
- `shift_out` in 1: TDO bit from the TAP FSM, valid while `tap_shift` is high.
- `rx_data` out 8, `rx_nbits` out 4, `rx_last` out 1: readback word. Unused upper bits of `rx_data` are 0.
- `rx_valid` out 1 / `rx_ready` in 1: downstream handshake.
- `busy` out 1: any TX bit is buffered or any RX bits are pending.
- `err_underrun` out 1, `err_overflow` out 1: sticky error flags.
- `err_clear` in 1: clears both sticky flags.

## Operation
- TX storage is two stages:
  - CUR: shift register plus `cur_cnt` (remaining bits, 0..8) and `cur_last`.
  - NXT: byte, bit count, `nxt_last`, `nxt_valid`.
- `tx_ready` = !`nxt_valid`, driven from registered state only.
- On accept: NXT ← {data, last ? nbits : 8, last}.
- CUR reload from NXT happens when `cur_cnt`==0, or when `cur_cnt`==1 and a bit is consumed this cycle. If both a reload and an accept happen in the same cycle, the NXT move and the new NXT write occur together.
- `shift_in` = CUR[0] when `cur_cnt`>0, else 0.
- Consume: at a posedge with `tap_shift`=1 and `cur_cnt`>0, shift CUR right and decrement `cur_cnt`.
- If `tap_shift`=1 and `cur_cnt`==0:
  - set `err_underrun`;
  - treat the TDI bit as 0;
  - still capture the TDO bit.
- avail = `cur_cnt` + (`nxt_valid` ? nxt_cnt : 0).
- `shift_ready` = (avail ≥ 2) | (avail==1 & `cur_last`). This form is what lets the TAP FSM:
  - skip SHIFT from CAPTURE when the buffer is empty;
  - exit to PAUSE on the last buffered bit;
  - resume from PAUSE once a byte arrives.
- RX assembly register `acc[7:0]` with `acc_cnt` (0..7). On each `tap_shift` posedge: acc[acc_cnt] ← `shift_out`, and `acc_cnt` increments.
- RX push to the FIFO happens in either case:
  - when the bit just written lands at index 7 — push {acc, 8, last_bit};
  - when the bit consumed was the final bit of a `tx_last` byte (last_bit=1) — push {acc, acc_cnt+1, 1}.
  - After either push, `acc` and `acc_cnt` clear.
- A push into a full RX FIFO drops the word and sets `err_overflow`. JTAG shifting is never stalled.
- RX FIFO: `rx_valid` = !empty. The output fields always show the head entry. Pop on `rx_valid` & `rx_ready`. A push and a pop in the same cycle are allowed when the FIFO is full-with-pop.
- Sticky flags: set has priority over `err_clear` in the same cycle.

## Timing
- Reset values (`rst_n`=0 at posedge):
  - all counters 0; CUR, NXT, `acc`, FIFO pointers cleared;
  - `tx_ready`=1, `shift_in`=0, `shift_ready`=0, `rx_valid`=0, `busy`=0;
  - `rx_data`/`rx_nbits`/`rx_last` = 0;
  - both error flags 0.
- Reset mid-transfer discards all buffered TX and RX data. There is no partial flush.
- `shift_in` and `shift_ready` are combinational from registered state. They change only after posedges and are stable over the TAP FSM's negedge output register.
- TX latency: a byte accepted at edge N is in NXT after N. It is in CUR and driving `shift_in` after N+1 if CUR was empty.
- Throughput: one byte per 8 shift cycles is sustained when upstream keeps `tx_valid` high.
- RX latency: the word is visible on `rx_valid` the cycle after the posedge that captured its final bit.
- `shift_out` is sampled only at posedges where `tap_shift`=1. Cycles where `tap_shift`=0 (PAUSE, EXIT) leave `acc` untouched, so a byte may span a pause.

## Test plan
- Send 0xA5 (last, nbits=8) with `tap_shift` held high for 8 cycles -> `shift_in` sequence 1,0,1,0,0,1,0,1; `shift_ready` stays 1 through the 8th bit; with TDO looped to TDI, rx = {0xA5, 8, last=1}.
- Send 0x3 with nbits=2, last -> exactly 2 bits shifted (1,1); rx = {0x03, 2, 1}; upper `rx_data` bits are 0.
- Send 0xFF non-last, then stall upstream -> `shift_ready` drops to 0 while the 8th bit is current; drop `tap_shift` for 5 cycles (pause), then send 0x00 last -> `shift_ready` returns to 1; after 8 more shift cycles rx = {0xFF,8,0} and then {0x00,8,1}.
- Hold `tap_shift` high with an empty buffer for 3 cycles -> `shift_in`=0 and `err_underrun`=1 until `err_clear`.
- With `rx_ready`=0 and RX_DEPTH=4, shift 5 full bytes -> 4 entries held, `err_overflow`=1; pops return bytes 1..4 in order.
- Assert `rst_n`=0 during bit 3 of a byte -> all outputs take their reset values next cycle and no rx word is emitted.

Source files
------------

// File: rtl/jtag_shift_serdes_if.sv
// rtl/jtag_shift_serdes_if.sv - host-side TX byte stream and RX readback stream
interface jtag_shift_serdes_if;
  logic [7:0] tx_data;
  logic [3:0] tx_nbits;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic [3:0] rx_nbits;
  logic       rx_last;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output tx_data, tx_nbits, tx_last, tx_valid,
    input  tx_ready,
    input  rx_data, rx_nbits, rx_last, rx_valid,
    output rx_ready
  );

  modport slave (
    input  tx_data, tx_nbits, tx_last, tx_valid,
    output tx_ready,
    output rx_data, rx_nbits, rx_last, rx_valid,
    input  rx_ready
  );
endinterface

// File: rtl/jtag_shift_serdes.sv
// rtl/jtag_shift_serdes.sv - byte/bit bridge between host stream FIFOs and the TAP shift port
// TX: two-stage CUR/NXT byte buffer feeding shift_in LSB-first; RX: bit packer into a small FIFO.
module jtag_shift_serdes #(
  parameter int RX_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  jtag_shift_serdes_if.slave  host,
  output logic                shift_in,
  output logic                shift_ready,
  input  logic                tap_shift,
  input  logic                shift_out,
  output logic                busy,
  output logic                err_underrun,
  output logic                err_overflow,
  input  logic                err_clear
);
  localparam int PW = $clog2(RX_DEPTH);

  logic [7:0] cur_sr;
  logic [3:0] cur_cnt;
  logic       cur_last;
  logic [7:0] nxt_data;
  logic [3:0] nxt_cnt;
  logic       nxt_last;
  logic       nxt_valid;
  logic [7:0] acc;
  logic [2:0] acc_cnt;
  logic [7:0] fifo_data  [RX_DEPTH];
  logic [3:0] fifo_nbits [RX_DEPTH];
  logic       fifo_last  [RX_DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;

  logic       accept;
  logic       consume;
  logic       underrun;
  logic       reload;
  logic       last_bit;
  logic [4:0] avail;
  logic [7:0] acc_wr;
  logic       word_done;
  logic [3:0] word_nbits;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       overflow;

  assign host.tx_ready = !nxt_valid;
  assign accept   = host.tx_valid & !nxt_valid;
  assign consume  = tap_shift & (cur_cnt != 4'd0);
  assign underrun = tap_shift & (cur_cnt == 4'd0);
  // Reload on the same edge the final CUR bit leaves, so back-to-back bytes shift without a gap.
  assign reload   = nxt_valid & ((cur_cnt == 4'd0) | ((cur_cnt == 4'd1) & consume));
  assign last_bit = consume & (cur_cnt == 4'd1) & cur_last;
  assign avail    = {1'b0, cur_cnt} + (nxt_valid ? {1'b0, nxt_cnt} : 5'd0);

  assign shift_in    = (cur_cnt != 4'd0) ? cur_sr[0] : 1'b0;
  assign shift_ready = (avail >= 5'd2) | ((avail == 5'd1) & cur_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_sr    <= '0;
      cur_cnt   <= '0;
      cur_last  <= 1'b0;
      nxt_data  <= '0;
      nxt_cnt   <= '0;
      nxt_last  <= 1'b0;
      nxt_valid <= 1'b0;
    end else begin
      if (reload) begin
        cur_sr   <= nxt_data;
        cur_cnt  <= nxt_cnt;
        cur_last <= nxt_last;
      end else if (consume) begin
        cur_sr  <= {1'b0, cur_sr[7:1]};
        cur_cnt <= cur_cnt - 4'd1;
        if (cur_cnt == 4'd1) begin
          cur_last <= 1'b0;
        end
      end
      if (accept) begin
        nxt_data  <= host.tx_data;
        nxt_cnt   <= host.tx_last ? host.tx_nbits : 4'd8;
        nxt_last  <= host.tx_last;
        nxt_valid <= 1'b1;
      end else if (reload) begin
        nxt_valid <= 1'b0;
      end
    end
  end

  // The TDO bit is captured even on underrun, so RX framing tracks TAP shift cycles exactly.
  always_comb begin
    acc_wr          = acc;
    acc_wr[acc_cnt] = shift_out;
  end

  assign word_done  = tap_shift & ((acc_cnt == 3'd7) | last_bit);
  assign word_nbits = {1'b0, acc_cnt} + 4'd1;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop        = !fifo_empty & host.rx_ready;
  assign push       = word_done & (!fifo_full | pop);
  assign overflow   = word_done & fifo_full & !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (tap_shift) begin
      if (word_done) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        acc     <= acc_wr;
        acc_cnt <= acc_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RX_DEPTH; i++) begin
        fifo_data[i]  <= '0;
        fifo_nbits[i] <= '0;
        fifo_last[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr[PW-1:0]]  <= acc_wr;
        fifo_nbits[wr_ptr[PW-1:0]] <= word_nbits;
        fifo_last[wr_ptr[PW-1:0]]  <= last_bit;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign host.rx_data  = fifo_data[rd_ptr[PW-1:0]];
  assign host.rx_nbits = fifo_nbits[rd_ptr[PW-1:0]];
  assign host.rx_last  = fifo_last[rd_ptr[PW-1:0]];
  assign host.rx_valid = !fifo_empty;

  assign busy = (cur_cnt != 4'd0) | nxt_valid | (acc_cnt != 3'd0) | !fifo_empty;

  // A new error event outranks a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (underrun) begin
        err_underrun <= 1'b1;
      end else if (err_clear) begin
        err_underrun <= 1'b0;
      end
      if (overflow) begin
        err_overflow <= 1'b1;
      end else if (err_clear) begin
        err_overflow <= 1'b0;
      end
    end
  end
endmodule
